fetch_unit: RTL and testbench

Instruction fetch stage for the reduced RISC-V core, and the supplying end of the control unit's instruction path. It owns the fetch PC, issues one-at-a-time read requests to instruction memory over a req/ack handshake, and buffers returned words in a 2-entry FIFO. It presents each word with its PC to decode/control over a valid/ready handshake. It accepts the branch redirect (PCsrc + target) back from control, flushes stale instructions, and restarts fetch at the target.

---
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC, req/ack memory port,
// 2-entry instruction FIFO and branch redirect with stale-data drain.
module fetch_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] branch_target
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]               state;
  logic [1:0]               state_n;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] pc_n;
  logic [ADDRESS_WIDTH-1:0] tgt;
  logic [ADDRESS_WIDTH-1:0] tgt_n;
  logic [ADDRESS_WIDTH-1:0] redir;

  logic [1:0]               count;
  logic [1:0]               count_n;
  logic [DATA_WIDTH-1:0]    d0;
  logic [DATA_WIDTH-1:0]    d1;
  logic [ADDRESS_WIDTH-1:0] a0;
  logic [ADDRESS_WIDTH-1:0] a1;

  logic push;
  logic pop;
  logic wr0;
  logic issue;

  assign redir = branch_target & ~ADDRESS_WIDTH'(3);

  assign pop  = (count != 2'd0) && instr_ready;
  assign push = (state == REQ) && imem_ack && !PCsrc;

  // New word lands in head slot when the FIFO is (or becomes) empty
  assign wr0 = push && (count == (pop ? 2'd1 : 2'd0));

  always_comb begin
    if (PCsrc) begin
      count_n = 2'd0;
    end else begin
      count_n = count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign issue = (count_n != 2'd2);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    tgt_n   = tgt;
    case (state)
      IDLE: begin
        if (PCsrc) begin
          state_n = REQ;
          pc_n    = redir;
        end else if (issue) begin
          state_n = REQ;
        end
      end
      REQ: begin
        if (PCsrc) begin
          if (imem_ack) begin
            state_n = REQ;
            pc_n    = redir;
          end else begin
            state_n = DRAIN;
            tgt_n   = redir;
          end
        end else if (imem_ack) begin
          pc_n    = pc + ADDRESS_WIDTH'(4);
          state_n = issue ? REQ : IDLE;
        end
      end
      DRAIN: begin
        // Outstanding word belongs to the abandoned path; drop it
        if (imem_ack) begin
          state_n = REQ;
          pc_n    = PCsrc ? redir : tgt;
        end else if (PCsrc) begin
          tgt_n = redir;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      tgt   <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      tgt   <= tgt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      d0    <= '0;
      d1    <= '0;
      a0    <= '0;
      a1    <= '0;
    end else if (PCsrc) begin
      count <= 2'd0;
    end else begin
      count <= count_n;
      if (pop && !wr0) begin
        d0 <= d1;
        a0 <= a1;
      end
      if (wr0) begin
        d0 <= imem_rdata;
        a0 <= pc;
      end else if (push) begin
        d1 <= imem_rdata;
        a1 <= pc;
      end
    end
  end

  assign imem_req    = (state != IDLE);
  assign imem_addr   = pc;
  assign instr       = d0;
  assign instr_pc    = a0;
  assign instr_valid = (count != 2'd0);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench with memory model and
// queue-based scoreboard of the expected program-order PC stream.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCsrc;
  logic [31:0] branch_target;

  int checks;
  int failures;
  int npop;
  int wait_min;
  int wait_max;
  int wait_left;
  bit force_ack;

  logic [31:0] pend_q[$];

  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .PCsrc(PCsrc),
    .branch_target(branch_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp,
               $time);
    end
  endtask

  // memory: ack after wait_left idle cycles of an outstanding request
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    wait_left  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (force_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = memf(imem_addr);
      end else if (imem_req) begin
        if (wait_left == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = memf(imem_addr);
          wait_left  = $urandom_range(wait_max, wait_min);
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = '0;
          wait_left--;
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [31:0] exp_pc;
    logic        p_req;
    logic        p_ack;
    logic        p_pcsrc;
    logic        p_rst;
    logic [31:0] p_addr;
    exp_pc  = 32'h0;
    p_req   = 1'b0;
    p_ack   = 1'b0;
    p_pcsrc = 1'b0;
    p_rst   = 1'b0;
    p_addr  = '0;
    forever begin
      @(posedge clk);
      #6;
      if (rst) begin
        if (p_rst) begin
          chk("reset_req", {31'd0, imem_req}, 32'd0);
          chk("reset_addr", imem_addr, 32'h0);
          chk("reset_valid", {31'd0, instr_valid}, 32'd0);
          chk("reset_instr", instr, 32'h0);
          chk("reset_pc", instr_pc, 32'h0);
        end
        exp_pc = 32'h0;
        pend_q.delete();
      end else begin
        if (p_pcsrc && !p_rst)
          chk("flush_valid", {31'd0, instr_valid}, 32'd0);
        if (p_req && !p_ack && !p_rst) begin
          chk("hold_req", {31'd0, imem_req}, 32'd1);
          chk("hold_addr", imem_addr, p_addr);
        end
        if (instr_valid && instr_ready) begin
          chk("pop_pc", instr_pc, exp_pc);
          chk("pop_data", instr, memf(exp_pc));
          exp_pc = exp_pc + 32'd4;
          npop++;
        end
        if (PCsrc) begin
          if (pend_q.size() == 0) begin
            failures++;
            $display("FAIL redirect_queue empty t=%0t", $time);
          end else begin
            exp_pc = pend_q.pop_front();
          end
        end
      end
      p_req   = imem_req;
      p_ack   = imem_ack;
      p_pcsrc = PCsrc;
      p_rst   = rst;
      p_addr  = imem_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [31:0] t);
    PCsrc         = 1'b1;
    branch_target = t;
    pend_q.push_back(t & 32'hFFFF_FFFC);
  endtask

  task automatic find_wait(input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (imem_req && !imem_ack && wait_left >= 2) begin
        found = 1;
        break;
      end
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp_a;
    logic [31:0] old;
    int          np0;
    bit          moved;
    checks        = 0;
    failures      = 0;
    npop          = 0;
    rst           = 1'b1;
    force_ack     = 1'b1;
    instr_ready   = 1'b0;
    PCsrc         = 1'b0;
    branch_target = '0;
    wait_min      = 0;
    wait_max      = 0;
    repeat (3) step();
    rst         = 1'b0;
    force_ack   = 1'b0;
    instr_ready = 1'b1;
    step();
    chk("release_req", {31'd0, imem_req}, 32'd1);
    chk("release_addr", imem_addr, 32'h0);
    chk("release_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_pc", instr_pc, 32'h0);
    exp_a = 32'h8;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stream_req", {31'd0, imem_req}, 32'd1);
      chk("stream_valid", {31'd0, instr_valid}, 32'd1);
      chk("stream_addr", imem_addr, exp_a);
      exp_a = exp_a + 32'd4;
    end
    // backpressure: FIFO fills, request drops, reissues after one pop
    instr_ready = 1'b0;
    repeat (3) begin
      step();
      chk("bp_req_low", {31'd0, imem_req}, 32'd0);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("bp_reissue", {31'd0, imem_req}, 32'd1);
    chk("bp_addr", imem_addr, exp_a);
    repeat (2) step();
    // redirect with full FIFO and same-cycle pop
    instr_ready = 1'b1;
    redirect(32'h103);
    step();
    PCsrc = 1'b0;
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h100);
    repeat (5) step();
    // wrap through the top of the address space
    redirect(32'hFFFF_FFF8);
    step();
    PCsrc = 1'b0;
    chk("wrap_a0", imem_addr, 32'hFFFF_FFF8);
    step();
    chk("wrap_a1", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_a2", imem_addr, 32'h0);
    repeat (4) step();
    // drain: slow memory, two redirects while the old fetch is pending
    wait_min = 3;
    wait_max = 3;
    find_wait("drain_find");
    old = imem_addr;
    redirect(32'h40);
    step();
    chk("drain_hold", imem_addr, old);
    redirect(32'h80);
    step();
    PCsrc = 1'b0;
    moved = 0;
    for (int i = 0; i < 12; i++) begin
      if (imem_addr != old) begin
        moved = 1;
        break;
      end
      step();
    end
    chk("drain_moved", {31'd0, moved}, 32'd1);
    chk("drain_target", imem_addr, 32'h80);
    repeat (12) step();
    // reset while a request is outstanding, ack forced during reset
    find_wait("midrst_find");
    rst       = 1'b1;
    force_ack = 1'b1;
    step();
    step();
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_addr", imem_addr, 32'h0);
    rst       = 1'b0;
    force_ack = 1'b0;
    wait_min  = 0;
    wait_max  = 0;
    step();
    chk("midrst_rel_req", {31'd0, imem_req}, 32'd1);
    chk("midrst_rel_addr", imem_addr, 32'h0);
    repeat (8) step();
    // random traffic
    wait_max = 2;
    for (int i = 0; i < 1500; i++) begin
      instr_ready = ($urandom_range(9, 0) < 7);
      if ($urandom_range(19, 0) == 0) begin
        if ($urandom_range(3, 0) == 0)
          redirect(32'hFFFF_FFF0 | 32'($urandom_range(15, 0)));
        else
          redirect($urandom);
      end else begin
        PCsrc = 1'b0;
      end
      step();
    end
    PCsrc       = 1'b0;
    instr_ready = 1'b1;
    np0         = npop;
    repeat (30) step();
    chk("progress", {31'd0, npop > np0}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
